// File: rtl/pkg_pflags.sv
// Shared types for the processor flags controller.
// Flag slots, flag-op and condition encodings, FSM states.
package pkg_pflags;

   localparam int PF_MSB_POS = 1;
   localparam int PF_WIDTH   = PF_MSB_POS + 1;

   typedef enum int {
      PF_SLOT_Z = 0,
      PF_SLOT_C = 1
   } pf_slot_e;

   typedef enum logic [1:0] {
      PFI_SET  = 2'd0,
      PFI_CLR  = 2'd1,
      PFI_TGL  = 2'd2,
      PFI_LOAD = 2'd3
   } pf_instr_op_e;

   typedef enum logic [2:0] {
      PF_COND_ALWAYS    = 3'd0,
      PF_COND_Z         = 3'd1,
      PF_COND_NZ        = 3'd2,
      PF_COND_C         = 3'd3,
      PF_COND_NC        = 3'd4,
      PF_COND_Z_OR_C    = 3'd5,
      PF_COND_NZ_AND_NC = 3'd6,
      PF_COND_NEVER     = 3'd7
   } pf_cond_e;

   typedef enum logic [1:0] {
      PFC_IDLE    = 2'd0,
      PFC_SAVE    = 2'd1,
      PFC_RESTORE = 2'd2
   } pfc_state_e;

   function automatic logic pf_cond_eval(
      input logic [2:0] cc,
      input logic       z,
      input logic       c
   );
      logic r;
      r = 1'b0;
      case (cc)
         PF_COND_ALWAYS:    r = 1'b1;
         PF_COND_Z:         r = z;
         PF_COND_NZ:        r = ~z;
         PF_COND_C:         r = c;
         PF_COND_NC:        r = ~c;
         PF_COND_Z_OR_C:    r = z | c;
         PF_COND_NZ_AND_NC: r = ~z & ~c;
         default:           r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/proc_flags_stack.sv
// LIFO shadow stack for flag context save/restore.
// Pointer counts 0..DEPTH with no wrap; pushes when full and pops when empty are ignored.
module proc_flags_stack #(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [PW-1:0] ptr;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] top_idx;
   logic          do_push;
   logic          do_pop;

   assign full    = (ptr == PW'(DEPTH));
   assign empty   = (ptr == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign top_idx = AW'(ptr - PW'(1));
   assign dout    = mem[top_idx];

   // Entry count; the only state that needs reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (do_push) begin
         ptr <= ptr + PW'(1);
      end else if (do_pop) begin
         ptr <= ptr - PW'(1);
      end
   end

   // Storage write at the next free slot.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/proc_flags_ctrl.sv
// Processor flags register with ALU/instr/context write arbitration.
// Optional branch condition output under PROC_FLAGS_CTRL_COND_EN.
module proc_flags_ctrl
   import pkg_pflags::*;
#(
   parameter int PFW         = PF_WIDTH,
   parameter int STACK_DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           alu_upd_valid,
   input  logic [PFW-1:0] alu_upd_mask,
   input  logic [PFW-1:0] alu_upd_flags,
   input  logic           instr_req,
   input  logic [1:0]     instr_op,
   input  logic [PFW-1:0] instr_mask,
   input  logic [PFW-1:0] instr_data,
   output logic           instr_grant,
   input  logic           ctx_save_req,
   input  logic           ctx_restore_req,
   output logic           ctx_ack,
   input  logic           err_clr,
   output logic [PFW-1:0] flags_out,
   output logic           stack_full,
   output logic           stack_empty,
   output logic           err_ovf,
   output logic           err_unf,
   output logic           err_coll
`ifdef PROC_FLAGS_CTRL_COND_EN
   ,
   input  logic [2:0]     cond_code,
   output logic           cond_true
`endif
);

   pfc_state_e     state;
   pfc_state_e     state_nxt;
   logic [PFW-1:0] flags_nxt;
   logic [PFW-1:0] alu_val;
   logic [PFW-1:0] instr_res;
   logic [PFW-1:0] stk_top;
   logic           push;
   logic           pop;
   logic           ovf_set;
   logic           unf_set;
   logic           coll_set;

   proc_flags_stack #(
      .W     (PFW),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (flags_out),
      .dout  (stk_top),
      .full  (stack_full),
      .empty (stack_empty)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= PFC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: context ops last one cycle; save beats restore.
   always_comb begin
      state_nxt = PFC_IDLE;
      if (state == PFC_IDLE) begin
         if (ctx_save_req) begin
            state_nxt = PFC_SAVE;
         end else if (ctx_restore_req) begin
            state_nxt = PFC_RESTORE;
         end
      end
   end

   // FSM outputs; gated by reset so an aborted op never acks.
   always_comb begin
      instr_grant = ~reset & instr_req & (state == PFC_IDLE)
                  & ~ctx_save_req & ~ctx_restore_req;
      ctx_ack     = ~reset & (state != PFC_IDLE);
      push        = ~reset & (state == PFC_SAVE);
      pop         = ~reset & (state == PFC_RESTORE);
      ovf_set     = (state == PFC_SAVE) & stack_full;
      unf_set     = (state == PFC_RESTORE) & stack_empty;
      coll_set    = (state == PFC_RESTORE) & alu_upd_valid;
   end

   // Next flags: instr bits override ALU bits; restore overrides both.
   always_comb begin
      alu_val   = alu_upd_valid
                ? (flags_out & ~alu_upd_mask) | (alu_upd_flags & alu_upd_mask)
                : flags_out;
      instr_res = flags_out;
      case (instr_op)
         PFI_SET:  instr_res = flags_out | instr_mask;
         PFI_CLR:  instr_res = flags_out & ~instr_mask;
         PFI_TGL:  instr_res = flags_out ^ instr_mask;
         default:  instr_res = (flags_out & ~instr_mask)
                             | (instr_data & instr_mask);
      endcase
      flags_nxt = alu_val;
      if (instr_grant) begin
         flags_nxt = (instr_res & instr_mask) | (alu_val & ~instr_mask);
      end
      if (state == PFC_RESTORE) begin
         flags_nxt = stack_empty ? flags_out : stk_top;
      end
   end

   // Flags register and sticky errors; a new error beats err_clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_out <= '0;
         err_ovf   <= 1'b0;
         err_unf   <= 1'b0;
         err_coll  <= 1'b0;
      end else begin
         flags_out <= flags_nxt;
         err_ovf   <= ovf_set  | (err_ovf  & ~err_clr);
         err_unf   <= unf_set  | (err_unf  & ~err_clr);
         err_coll  <= coll_set | (err_coll & ~err_clr);
      end
   end

`ifdef PROC_FLAGS_CTRL_COND_EN
   assign cond_true = pf_cond_eval(cond_code,
                                   flags_out[PF_SLOT_Z],
                                   flags_out[PF_SLOT_C]);
`endif

endmodule

// File: tb/tb_proc_flags_ctrl.sv
// Directed scoreboard bench for proc_flags_ctrl.
// Expected values come from a behavioural model with a queue as the stack.
module tb_proc_flags_ctrl;
   import pkg_pflags::*;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       alu_upd_valid;
   logic [1:0] alu_upd_mask;
   logic [1:0] alu_upd_flags;
   logic       instr_req;
   logic [1:0] instr_op;
   logic [1:0] instr_mask;
   logic [1:0] instr_data;
   logic       instr_grant;
   logic       ctx_save_req;
   logic       ctx_restore_req;
   logic       ctx_ack;
   logic       err_clr;
   logic [1:0] flags_out;
   logic       stack_full;
   logic       stack_empty;
   logic       err_ovf;
   logic       err_unf;
   logic       err_coll;
`ifdef PROC_FLAGS_CTRL_COND_EN
   logic [2:0] cond_code = 3'd0;
   logic       cond_true;
`endif

   always #5 clk = ~clk;

   proc_flags_ctrl #(.STACK_DEPTH(D)) dut (
      .clk             (clk),
      .reset           (reset),
      .alu_upd_valid   (alu_upd_valid),
      .alu_upd_mask    (alu_upd_mask),
      .alu_upd_flags   (alu_upd_flags),
      .instr_req       (instr_req),
      .instr_op        (instr_op),
      .instr_mask      (instr_mask),
      .instr_data      (instr_data),
      .instr_grant     (instr_grant),
      .ctx_save_req    (ctx_save_req),
      .ctx_restore_req (ctx_restore_req),
      .ctx_ack         (ctx_ack),
      .err_clr         (err_clr),
      .flags_out       (flags_out),
      .stack_full      (stack_full),
      .stack_empty     (stack_empty),
      .err_ovf         (err_ovf),
      .err_unf         (err_unf),
      .err_coll        (err_coll)
`ifdef PROC_FLAGS_CTRL_COND_EN
      ,
      .cond_code       (cond_code),
      .cond_true       (cond_true)
`endif
   );

   typedef struct {
      logic [1:0] flags;
      logic       grant;
      logic       ack;
      logic       full;
      logic       empty;
      logic       ovf;
      logic       unf;
      logic       coll;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;

   logic [1:0] m_flags = 2'b00;
   logic [1:0] m_stk[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic       m_coll = 1'b0;
   int         m_st = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      reset = 1'b0;
      alu_upd_valid = 1'b0;
      alu_upd_mask = 2'b00;
      alu_upd_flags = 2'b00;
      instr_req = 1'b0;
      instr_op = PFI_SET;
      instr_mask = 2'b00;
      instr_data = 2'b00;
      ctx_save_req = 1'b0;
      ctx_restore_req = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic load(input logic [1:0] v);
      instr_req = 1'b1;
      instr_op = PFI_LOAD;
      instr_mask = 2'b11;
      instr_data = v;
   endtask

   // One clock: model the cycle, push expectation, check comb then regs.
   task automatic cyc(input string tag);
      exp_t       e;
      logic       g;
      logic [1:0] ires;
      logic [1:0] nf;
      logic       nov;
      logic       nun;
      logic       nco;
      g = ~reset & instr_req & (m_st == 0) & ~ctx_save_req & ~ctx_restore_req;
      e.grant = g;
      e.ack = ~reset & (m_st != 0);
      if (reset) begin
         m_flags = 2'b00;
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_coll = 1'b0;
         m_st = 0;
      end else begin
         nf = m_flags;
         nov = 1'b0;
         nun = 1'b0;
         nco = 1'b0;
         if (m_st == 2) begin
            if (m_stk.size() > 0) nf = m_stk.pop_back();
            else nun = 1'b1;
            nco = alu_upd_valid;
         end else begin
            case (instr_op)
               PFI_SET: ires = m_flags | instr_mask;
               PFI_CLR: ires = m_flags & ~instr_mask;
               PFI_TGL: ires = m_flags ^ instr_mask;
               default: ires = instr_data;
            endcase
            for (int i = 0; i < 2; i++) begin
               if (g && instr_mask[i]) nf[i] = ires[i];
               else if (alu_upd_valid && alu_upd_mask[i])
                  nf[i] = alu_upd_flags[i];
            end
            if (m_st == 1) begin
               if (m_stk.size() < D) m_stk.push_back(m_flags);
               else nov = 1'b1;
            end
         end
         m_ovf = nov | (m_ovf & ~err_clr);
         m_unf = nun | (m_unf & ~err_clr);
         m_coll = nco | (m_coll & ~err_clr);
         if (m_st == 0)
            m_st = ctx_save_req ? 1 : (ctx_restore_req ? 2 : 0);
         else
            m_st = 0;
         m_flags = nf;
      end
      e.flags = m_flags;
      e.full = (m_stk.size() == D);
      e.empty = (m_stk.size() == 0);
      e.ovf = m_ovf;
      e.unf = m_unf;
      e.coll = m_coll;
      sb.push_back(e);
      #3;
      chk({tag, "_grant"}, 32'(instr_grant), 32'(sb[0].grant));
      chk({tag, "_ack"}, 32'(ctx_ack), 32'(sb[0].ack));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, "_flags"}, 32'(flags_out), 32'(e.flags));
      chk({tag, "_full"}, 32'(stack_full), 32'(e.full));
      chk({tag, "_empty"}, 32'(stack_empty), 32'(e.empty));
      chk({tag, "_ovf"}, 32'(err_ovf), 32'(e.ovf));
      chk({tag, "_unf"}, 32'(err_unf), 32'(e.unf));
      chk({tag, "_coll"}, 32'(err_coll), 32'(e.coll));
   endtask

   initial begin
      idle_in();
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc("rst0");
      cyc("rst1");

      // ALU and CLR together from 00 -> 10
      idle_in();
      alu_upd_valid = 1'b1;
      alu_upd_mask = 2'b11;
      alu_upd_flags = 2'b11;
      instr_req = 1'b1;
      instr_op = PFI_CLR;
      instr_mask = 2'b01;
      cyc("t1");
      chk("t1_val", 32'(flags_out), 32'h2);

      // Save 01, load 10, restore 01
      idle_in(); load(2'b01); cyc("t2_ld");
      idle_in(); ctx_save_req = 1'b1; cyc("t2_sv");
      idle_in(); cyc("t2_sack");
      load(2'b10); cyc("t2_ld2");
      idle_in(); ctx_restore_req = 1'b1; cyc("t2_rs");
      idle_in(); cyc("t2_rack");
      chk("t2_val", 32'(flags_out), 32'h1);

      // Fill stack with 0,1,2,3 then overflow with 0
      for (int i = 0; i < 5; i++) begin
         idle_in(); load(2'(i)); cyc("t3_ld");
         idle_in(); ctx_save_req = 1'b1; cyc("t3_sv");
         idle_in(); cyc("t3_sack");
      end
      idle_in(); ctx_restore_req = 1'b1; cyc("t3_rs");
      idle_in(); cyc("t3_top");
      chk("t3_top_val", 32'(flags_out), 32'h3);
      err_clr = 1'b1; cyc("t3_clr");
      for (int i = 0; i < 3; i++) begin
         idle_in(); ctx_restore_req = 1'b1; cyc("t3_drs");
         idle_in(); cyc("t3_dack");
      end

      // Underflow, err_clr loses to a new error, then clears
      idle_in(); load(2'b10); cyc("t4_ld");
      idle_in(); ctx_restore_req = 1'b1; cyc("t4_rs");
      idle_in(); cyc("t4_unf");
      ctx_restore_req = 1'b1; cyc("t4_rs2");
      idle_in(); err_clr = 1'b1; cyc("t4_race");
      err_clr = 1'b1; cyc("t4_clr");

      // Save+restore+instr together
      idle_in();
      instr_req = 1'b1;
      instr_op = PFI_TGL;
      instr_mask = 2'b11;
      ctx_save_req = 1'b1;
      ctx_restore_req = 1'b1;
      cyc("t5_both");
      ctx_save_req = 1'b0; cyc("t5_sack");
      cyc("t5_rs");
      ctx_restore_req = 1'b0; cyc("t5_rack");
      cyc("t5_grant");

      // ALU during launch and during restore; reset in SAVE
      idle_in(); load(2'b01); cyc("t6_ld");
      idle_in();
      ctx_save_req = 1'b1;
      alu_upd_valid = 1'b1;
      alu_upd_mask = 2'b10;
      alu_upd_flags = 2'b10;
      cyc("t6_sv");
      idle_in(); cyc("t6_sack");
      load(2'b00); cyc("t6_ld0");
      idle_in(); ctx_restore_req = 1'b1; cyc("t6_rs");
      idle_in();
      alu_upd_valid = 1'b1;
      alu_upd_mask = 2'b11;
      alu_upd_flags = 2'b01;
      cyc("t6_coll");
      idle_in(); err_clr = 1'b1; cyc("t6_clr");
      idle_in(); ctx_save_req = 1'b1; cyc("t6_sv2");
      idle_in(); cyc("t6_sack2");
      ctx_save_req = 1'b1; cyc("t6_sv3");
      idle_in(); reset = 1'b1; cyc("t6_rst");
      idle_in(); cyc("t6_post");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
